// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with double-buffered digit load.
// Optional leading-zero blanking is enabled with `define SEG_SCAN_BLANK_EN.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 2
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  over_in,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  ovf_led,
  output logic                  frame_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {S_GUARD, S_DRIVE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d, act_q, act_d;
  logic                pend_vld_q, pend_vld_d, povf_q, povf_d, ovf_q, ovf_d;
  logic                rdy_q, rdy_d, fd_q, fd_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                slot_end, frame_end, accept, commit, lit;
  logic [3:0]          nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0111111;  4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;  4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;  4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;  4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;  4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;  default: hex7 = 7'b1110001;
    endcase
  endfunction

  assign slot_end  = (cnt_q == CW'(PRESCALE-1));
  assign frame_end = slot_end && (idx_q == IW'(DIGITS-1));
  assign accept    = load && rdy_q;
  assign commit    = frame_end && pend_vld_q;
  assign nib       = act_q[4*idx_q +: 4];

`ifdef SEG_SCAN_BLANK_EN
  // Mask is derived from the pending buffer so it lands together with the commit.
  logic [DIGITS-1:0] blank_q, blank_d;
  always_comb begin
    logic nz;
    nz      = 1'b0;
    blank_d = '0;
    for (int k = DIGITS-1; k > 0; k--) begin
      nz         = nz | (|pend_q[4*k +: 4]);
      blank_d[k] = ~nz;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else if (commit) blank_q <= blank_d;
  end
  assign lit = ~blank_q[idx_q];
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    pend_d     = pend_q;
    povf_d     = povf_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    ovf_d      = ovf_q;
    state_d    = state_q;
    seg_d      = '0;
    an_d       = '0;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + 1'b1;
    end
    if (commit) begin
      act_d      = pend_q;
      ovf_d      = povf_q;
      pend_vld_d = 1'b0;
    end
    // accept and commit are exclusive: ready is low whenever pending is full
    if (accept) begin
      pend_d     = digits_in;
      povf_d     = over_in;
      pend_vld_d = 1'b1;
    end
    case (state_q)
      S_GUARD: if (cnt_q == CW'(GUARD-1)) state_d = S_DRIVE;
      S_DRIVE: if (slot_end)              state_d = S_GUARD;
      default:                            state_d = S_GUARD;
    endcase
    if (state_q == S_DRIVE) begin
      an_d[idx_q] = 1'b1;
      if (lit) seg_d = hex7(nib);
    end
    rdy_d = ~pend_vld_d;
    fd_d  = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_GUARD;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      povf_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      ovf_q      <= 1'b0;
      rdy_q      <= 1'b1;
      fd_q       <= 1'b0;
      seg_q      <= '0;
      an_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      povf_q     <= povf_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
      ovf_q      <= ovf_d;
      rdy_q      <= rdy_d;
      fd_q       <= fd_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign ready      = rdy_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign ovf_led    = ovf_q;
  assign frame_done = fd_q;
endmodule
